// File: rtl/oumux_sched.sv
// oumux_sched: command FIFO feeding the shared output-mux controller.
// Runs one burst at a time, counting beats and chaining without bubbles.
module oumux_sched #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_cmd_req,
  output logic             t_cmd_ack,
  input  logic [3:0]       t_cmd_sel,
  input  logic [LEN_W-1:0] t_cmd_len,
  output logic             i_oumux_req,
  input  logic             i_oumux_ack,
  output logic [3:0]       sel,
  output logic             cmd_done,
  output logic             busy,
  output logic [AW:0]      fifo_level,
  output logic             err_sel,
  input  logic             err_clr
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic             req_q;
  logic [3:0]       sel_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             done_q;
  logic             err_q;

  logic [3:0]       sel_mem_q [DEPTH];
  logic [LEN_W-1:0] len_mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      lvl_q;
  logic [AW:0]      lvl_d;

  logic full;
  logic empty;
  logic sel_ok;
  logic xfer;
  logic push;
  logic bad;
  logic beat;
  logic last;
  logic pop;

  assign full  = (lvl_q == (AW+1)'(DEPTH));
  assign empty = (lvl_q == '0);

  assign t_cmd_ack = ~full & ~reset;

  // Only destinations the mux can route are accepted into the FIFO.
  always_comb begin
    sel_ok = 1'b0;
    case (t_cmd_sel)
      4'd8, 4'd9, 4'd13, 4'd14, 4'd15: sel_ok = 1'b1;
      default:                         sel_ok = 1'b0;
    endcase
  end

  assign xfer = t_cmd_req & t_cmd_ack;
  assign push = xfer & sel_ok;
  assign bad  = xfer & ~sel_ok;

  assign beat = (state_q == RUN) & i_oumux_ack;
  assign last = beat & (cnt_q == len_q);
  assign pop  = ~empty & ((state_q == IDLE) | last);

  assign lvl_d = lvl_q
               + {{AW{1'b0}}, push}
               - {{AW{1'b0}}, pop};

  // FIFO storage; contents need no reset, the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem_q[wr_q] <= t_cmd_sel;
      len_mem_q[wr_q] <= t_cmd_len;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end

  // Burst sequencer: load a command, count beats, chain or go idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (pop) begin
        sel_q   <= sel_mem_q[rd_q];
        len_q   <= len_mem_q[rd_q];
        cnt_q   <= '0;
        state_q <= RUN;
        req_q   <= 1'b1;
      end else if (last) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Sticky illegal-select flag; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (bad) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign i_oumux_req = req_q;
  assign sel         = sel_q;
  assign cmd_done    = done_q;
  assign busy        = (state_q == RUN) | ~empty;
  assign fifo_level  = lvl_q;
  assign err_sel     = err_q;

endmodule

// File: tb/tb_oumux_sched.sv
// tb_oumux_sched: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_oumux_sched;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [3:0] csel = '0;
  logic [7:0] clen = '0;
  logic       oack = 1'b0;
  logic       clr = 1'b0;

  logic       t_cmd_ack;
  logic       i_oumux_req;
  logic [3:0] sel;
  logic       cmd_done;
  logic       busy;
  logic [2:0] fifo_level;
  logic       err_sel;

  always #5 clk = ~clk;

  oumux_sched dut (
    .clk         (clk),
    .reset       (rst),
    .t_cmd_req   (req),
    .t_cmd_ack   (t_cmd_ack),
    .t_cmd_sel   (csel),
    .t_cmd_len   (clen),
    .i_oumux_req (i_oumux_req),
    .i_oumux_ack (oack),
    .sel         (sel),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .err_sel     (err_sel),
    .err_clr     (clr)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference model: pending queue plus active burst's remaining beats
  typedef struct {
    logic [3:0] s;
    int         n;
  } cmd_t;

  cmd_t       mq[$];
  bit         m_act = 0;
  int         m_rem = 0;
  logic [3:0] m_sel = '0;
  bit         m_done = 0;
  bit         m_err = 0;
  bit         m_acc = 0;

  function automatic bit legal(logic [3:0] s);
    return s inside {4'd8, 4'd9, 4'd13, 4'd14, 4'd15};
  endfunction

  function automatic bit m_ack();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic void model_step();
    bit   ok, acc, bt, lst;
    cmd_t c;
    m_acc = 0;
    if (rst) begin
      mq.delete();
      m_act  = 0;
      m_rem  = 0;
      m_sel  = '0;
      m_done = 0;
      m_err  = 0;
      return;
    end
    ok  = legal(csel);
    acc = req && m_ack();
    m_acc = acc && ok;
    bt  = m_act && oack;
    lst = bt && (m_rem == 1);
    m_done = lst;
    if (bt) m_rem--;
    if (!m_act || lst) begin
      if (mq.size() != 0) begin
        c = mq.pop_front();
        m_sel = c.s;
        m_rem = c.n + 1;
        m_act = 1;
      end else begin
        m_act = 0;
      end
    end
    if (acc && ok) mq.push_back('{csel, int'(clen)});
    if (acc && !ok) m_err = 1;
    else if (clr) m_err = 0;
  endfunction

  // observation bookkeeping
  logic [3:0] obs[$];
  int nbeat, ndone, first, lastc, cyc;
  logic s_ack, s_req, s_done, s_busy, s_err;
  logic [3:0] s_sel;
  logic [2:0] s_lvl;

  task automatic clear_obs();
    obs.delete();
    nbeat = 0;
    ndone = 0;
    first = -1;
    lastc = -1;
  endtask

  task automatic cycle();
    @(negedge clk);
    s_ack  = t_cmd_ack;
    s_req  = i_oumux_req;
    s_sel  = sel;
    s_done = cmd_done;
    s_lvl  = fifo_level;
    s_busy = busy;
    s_err  = err_sel;
    chk("ack", t_cmd_ack, m_ack());
    chk("req", i_oumux_req, m_act);
    if (m_act) chk("sel", sel, m_sel);
    chk("done", cmd_done, m_done);
    chk("level", fifo_level, mq.size());
    chk("busy", busy, m_act || mq.size() != 0);
    chk("err", err_sel, m_err);
    if (i_oumux_req === 1'b1 && oack) begin
      obs.push_back(sel);
      nbeat++;
      if (first < 0) first = cyc;
      lastc = cyc;
    end
    if (cmd_done === 1'b1) ndone++;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic drv(bit r, bit q, logic [3:0] s, logic [7:0] l,
                     bit a, bit c);
    rst  = r;
    req  = q;
    csel = s;
    clen = l;
    oack = a;
    clr  = c;
  endtask

  task automatic drain(input int maxc);
    req = 0;
    clr = 0;
    for (int k = 0; k < maxc && (m_act || mq.size() != 0); k++)
      cycle();
    chk("drain_timeout", m_act || mq.size() != 0, 0);
    cycle();
    cycle();
  endtask

  typedef struct {
    bit rst, req;
    logic [3:0] csel;
    logic [7:0] clen;
    bit oack, clr;
    bit e_ack, e_req;
    logic [3:0] e_sel;
    bit e_done;
    int e_lvl;
    bit e_busy, e_err;
  } vec_t;

  function automatic vec_t mkv(bit r, bit q, logic [3:0] s,
      logic [7:0] l, bit a, bit c, bit ea, bit er, logic [3:0] es,
      bit ed, int el, bit eb, bit ee);
    vec_t v;
    v = '{r, q, s, l, a, c, ea, er, es, ed, el, eb, ee};
    return v;
  endfunction

  vec_t tbl[13];
  logic [3:0] exp3[6];
  logic [3:0] expf[12];
  logic [3:0] lg[5];
  int bad14;

  initial begin
    lg = '{4'd8, 4'd9, 4'd13, 4'd14, 4'd15};
    // single {9,3} burst, then illegal select / err_clr priority
    tbl[0]  = mkv(1,0, 0,0,1,0, 0,0,0,0,0,0,0);
    tbl[1]  = mkv(0,1, 9,3,1,0, 1,0,0,0,0,0,0);
    tbl[2]  = mkv(0,0, 0,0,1,0, 1,0,0,0,1,1,0);
    tbl[3]  = mkv(0,0, 0,0,1,0, 1,1,9,0,0,1,0);
    tbl[4]  = mkv(0,0, 0,0,1,0, 1,1,9,0,0,1,0);
    tbl[5]  = mkv(0,0, 0,0,1,0, 1,1,9,0,0,1,0);
    tbl[6]  = mkv(0,0, 0,0,1,0, 1,1,9,0,0,1,0);
    tbl[7]  = mkv(0,0, 0,0,1,0, 1,0,9,1,0,0,0);
    tbl[8]  = mkv(0,1,10,0,1,0, 1,0,9,0,0,0,0);
    tbl[9]  = mkv(0,1,10,0,1,1, 1,0,9,0,0,0,1);
    tbl[10] = mkv(0,0, 0,0,1,0, 1,0,9,0,0,0,1);
    tbl[11] = mkv(0,0, 0,0,1,1, 1,0,9,0,0,0,1);
    tbl[12] = mkv(0,0, 0,0,1,0, 1,0,9,0,0,0,0);

    cyc = 0;
    clear_obs();
    rst = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].rst, tbl[i].req, tbl[i].csel, tbl[i].clen,
          tbl[i].oack, tbl[i].clr);
      cycle();
      chk($sformatf("v%0d_ack", i), s_ack, tbl[i].e_ack);
      chk($sformatf("v%0d_req", i), s_req, tbl[i].e_req);
      chk($sformatf("v%0d_sel", i), s_sel, tbl[i].e_sel);
      chk($sformatf("v%0d_done", i), s_done, tbl[i].e_done);
      chk($sformatf("v%0d_lvl", i), s_lvl, tbl[i].e_lvl);
      chk($sformatf("v%0d_busy", i), s_busy, tbl[i].e_busy);
      chk($sformatf("v%0d_err", i), s_err, tbl[i].e_err);
    end

    // three back-to-back commands, no bubbles
    clear_obs();
    exp3 = '{4'd8, 4'd13, 4'd13, 4'd15, 4'd15, 4'd15};
    drv(0, 1, 8, 0, 1, 0);  cycle();
    drv(0, 1, 13, 1, 1, 0); cycle();
    drv(0, 1, 15, 2, 1, 0); cycle();
    drain(20);
    chk("three_beats", obs.size(), 6);
    for (int i = 0; i < 6 && i < obs.size(); i++)
      chk($sformatf("three_sel%0d", i), obs[i], exp3[i]);
    chk("three_done", ndone, 3);
    chk("three_span", lastc - first, 5);

    // fill while stalled, back-pressure, then ordered drain
    clear_obs();
    expf = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd13, 4'd13,
             4'd14, 4'd14, 4'd15, 4'd15, 4'd9, 4'd9};
    drv(0, 1, 8, 1, 0, 0);  cycle();
    drv(0, 1, 9, 1, 0, 0);  cycle();
    drv(0, 1, 13, 1, 0, 0); cycle();
    drv(0, 1, 14, 1, 0, 0); cycle();
    drv(0, 1, 15, 1, 0, 0); cycle();
    chk("fill_lvl3", s_lvl, 3);
    drv(0, 1, 9, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("full_noack", s_ack, 0);
      chk("full_lvl", s_lvl, 4);
    end
    oack = 1;
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        cycle();
        got = m_acc;
      end
      chk("full_accept_timeout", got, 1);
    end
    drain(50);
    chk("fill_beats", obs.size(), 12);
    for (int i = 0; i < 12 && i < obs.size(); i++)
      chk($sformatf("fill_sel%0d", i), obs[i], expf[i]);
    chk("fill_done", ndone, 6);

    // max-length burst under random stalls
    clear_obs();
    drv(0, 1, 14, 8'd255, 0, 0);
    cycle();
    req = 0;
    for (int k = 0; k < 3000 && (m_act || mq.size() != 0); k++) begin
      oack = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("long_timeout", m_act || mq.size() != 0, 0);
    oack = 0;
    cycle();
    cycle();
    bad14 = 0;
    foreach (obs[i]) if (obs[i] != 4'd14) bad14++;
    chk("long_beats", nbeat, 256);
    chk("long_sel", bad14, 0);
    chk("long_done", ndone, 1);

    // reset during beat 2 with two queued commands
    clear_obs();
    drv(0, 1, 8, 5, 1, 0);  cycle();
    drv(0, 1, 9, 0, 1, 0);  cycle();
    drv(0, 1, 13, 1, 1, 0); cycle();
    drv(1, 0, 0, 0, 1, 0);  cycle();
    chk("rst_beat2_req", s_req, 1);
    drv(0, 0, 0, 0, 1, 0);  cycle();
    chk("rst_req", s_req, 0);
    chk("rst_lvl", s_lvl, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    cycle();
    chk("rst_done2", s_done, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = 1'($urandom_range(0, 1));
      csel = ($urandom_range(0, 9) == 0)
             ? 4'($urandom_range(0, 15))
             : lg[$urandom_range(0, 4)];
      clen = 8'($urandom_range(0, 3));
      oack = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 0;
    oack = 1;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
